// File: rtl/vote_pkg.sv
// Shared types and helpers for the parametrised vote counter.
package vote_pkg;

    localparam int MAX_CAND = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        VOTED,
        REJ,
        WAIT_REL
    } state_e;

    function automatic int IDX_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int popcount(input logic [MAX_CAND-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_CAND; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

    // Index of the highest set bit; only meaningful for one-hot inputs.
    function automatic int onehot_idx(input logic [MAX_CAND-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CAND; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/vote_press_qualifier.sv
// Synchronises buttons/mode and qualifies a single-button press by hold time.
// Accept strobe fires on the edge where the hold count has reached HOLD_CYC; no backpressure.
module vote_press_qualifier
    import vote_pkg::*;
#(
    parameter int  NUM_CAND = 4,
    parameter int  HOLD_CYC = 10,
    localparam int IW       = IDX_W(NUM_CAND)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mode_i,
    input  logic [NUM_CAND-1:0] button_i,
    output logic                ms_o,
    output logic [NUM_CAND-1:0] bs_o,
    output logic                accept_o,
    output logic                reject_o,
    output logic [IW-1:0]       idx_o
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [NUM_CAND-1:0] button_s1_q, bs_q;
    logic                mode_s1_q, ms_q;
    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [MAX_CAND-1:0] bs_ext;
    logic [NUM_CAND-1:0] idx_mask;
    int                  pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            button_s1_q <= '0;
            bs_q        <= '0;
            mode_s1_q   <= 1'b0;
            ms_q        <= 1'b0;
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
        end else begin
            button_s1_q <= button_i;
            bs_q        <= button_s1_q;
            mode_s1_q   <= mode_i;
            ms_q        <= mode_s1_q;
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        bs_ext                 = '0;
        bs_ext[NUM_CAND-1:0]   = bs_q;
        pop                    = popcount(bs_ext);
        idx_mask               = {{(NUM_CAND-1){1'b0}}, 1'b1} << idx_q;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        accept_o = 1'b0;
        reject_o = 1'b0;
        // Results mode pre-empts everything so a half-held press can never count later.
        if (ms_q) begin
            state_d = WAIT_REL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop == 1) begin
                        state_d = ARM;
                        idx_d   = IW'(onehot_idx(bs_ext));
                        hold_d  = HW'(1);
                    end else if (pop > 1) begin
                        state_d  = REJ;
                        reject_o = 1'b1;
                    end
                end
                ARM: begin
                    if (bs_q == idx_mask) begin
                        if (hold_q < HW'(HOLD_CYC)) begin
                            hold_d = hold_q + 1'b1;
                        end else begin
                            state_d  = VOTED;
                            accept_o = 1'b1;
                        end
                    end else if (bs_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = REJ;
                        reject_o = 1'b1;
                    end
                end
                VOTED, REJ, WAIT_REL: begin
                    if (bs_q == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ms_o  = ms_q;
    assign bs_o  = bs_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/param_vote_counter.sv
// NUM_CAND-candidate voting machine with saturating tallies and a results display mux.
// vote_valid follows the accepting edge by one cycle, led lags a results-mode selection by one cycle; no backpressure.
module param_vote_counter
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mode,
    input  logic [NUM_CAND-1:0]               button,
    output logic [CNT_W-1:0]                  led,
    output logic                              vote_valid,
    output logic [IDX_W(NUM_CAND)-1:0]        vote_cand,
    output logic                              vote_invalid,
    output logic [CNT_W+IDX_W(NUM_CAND)-1:0]  total_votes
);

    localparam int IW = IDX_W(NUM_CAND);
    localparam int TW = CNT_W + IW;

    logic                ms, accept, reject;
    logic [NUM_CAND-1:0] bs;
    logic [IW-1:0]       idx;
    logic [MAX_CAND-1:0] bs_ext;

    logic [CNT_W-1:0] tally_q [NUM_CAND];
    logic [CNT_W-1:0] tally_d [NUM_CAND];
    logic [TW-1:0]    total_q, total_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [IW-1:0]    cand_q, cand_d;
    logic [CNT_W-1:0] led_q, led_d;
    logic             valid_q, invalid_q;

    vote_press_qualifier #(
        .NUM_CAND (NUM_CAND),
        .HOLD_CYC (HOLD_CYC)
    ) u_qual (
        .clk_i    (clk),
        .rst_ni   (reset),
        .mode_i   (mode),
        .button_i (button),
        .ms_o     (ms),
        .bs_o     (bs),
        .accept_o (accept),
        .reject_o (reject),
        .idx_o    (idx)
    );

    always_comb begin
        bs_ext               = '0;
        bs_ext[NUM_CAND-1:0] = bs;
        tally_d              = tally_q;
        total_d              = total_q;
        cand_d               = accept ? idx : cand_q;
        // A saturated tally leaves the total alone so the sum stays consistent.
        if (accept && (tally_q[idx] != '1)) begin
            tally_d[idx] = tally_q[idx] + 1'b1;
            if (total_q != '1) total_d = total_q + 1'b1;
        end
        sel_d = sel_q;
        if (ms && (popcount(bs_ext) == 1)) sel_d = IW'(onehot_idx(bs_ext));
        led_d = ms ? tally_q[sel_d] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tally_q   <= '{default: '0};
            total_q   <= '0;
            sel_q     <= '0;
            cand_q    <= '0;
            led_q     <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            tally_q   <= tally_d;
            total_q   <= total_d;
            sel_q     <= sel_d;
            cand_q    <= cand_d;
            led_q     <= led_d;
            valid_q   <= accept;
            invalid_q <= reject;
        end
    end

    assign led          = led_q;
    assign vote_valid   = valid_q;
    assign vote_cand    = cand_q;
    assign vote_invalid = invalid_q;
    assign total_votes  = total_q;

endmodule

// File: tb/tb_param_vote_counter.sv
// Scoreboard bench: stimulus queues expected vote/reject events, a negedge monitor consumes them.
module tb_param_vote_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_a, mode_b;
    logic [3:0] btn_a, btn_b;

    logic [7:0] led_a;
    logic       vv_a, vi_a;
    logic [1:0] vc_a;
    logic [9:0] tot_a;

    logic [1:0] led_b;
    logic       vv_b, vi_b;
    logic [1:0] vc_b;
    logic [3:0] tot_b;

    always #5 clk = ~clk;

    param_vote_counter #(.NUM_CAND(4), .CNT_W(8), .HOLD_CYC(10)) dut_a (
        .clk(clk), .reset(reset), .mode(mode_a), .button(btn_a),
        .led(led_a), .vote_valid(vv_a), .vote_cand(vc_a),
        .vote_invalid(vi_a), .total_votes(tot_a)
    );

    param_vote_counter #(.NUM_CAND(4), .CNT_W(2), .HOLD_CYC(10)) dut_b (
        .clk(clk), .reset(reset), .mode(mode_b), .button(btn_b),
        .led(led_b), .vote_valid(vv_b), .vote_cand(vc_b),
        .vote_invalid(vi_b), .total_votes(tot_b)
    );

    typedef struct {
        bit inv;
        int cand;
        int total;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && (vv_a || vi_a)) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_event: valid=%0b invalid=%0b with nothing expected", vv_a, vi_a);
            end else begin
                e_a = q_a.pop_front();
                check("a_event_is_invalid", 32'(vi_a), 32'(e_a.inv));
                if (!e_a.inv) begin
                    check("a_vote_cand", 32'(vc_a), e_a.cand);
                    check("a_total_votes", 32'(tot_a), e_a.total);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && (vv_b || vi_b)) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_event: valid=%0b invalid=%0b with nothing expected", vv_b, vi_b);
            end else begin
                e_b = q_b.pop_front();
                check("b_event_is_invalid", 32'(vi_b), 32'(e_b.inv));
                if (!e_b.inv) begin
                    check("b_vote_cand", 32'(vc_b), e_b.cand);
                    check("b_total_votes", 32'(tot_b), e_b.total);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_a(input logic [3:0] b, input int n);
        btn_a = b;
        cyc(n);
        btn_a = '0;
        cyc(8);
    endtask

    task automatic press_b(input logic [3:0] b, input int n);
        btn_b = b;
        cyc(n);
        btn_b = '0;
        cyc(8);
    endtask

    function automatic void exp_vote_a(input int c, input int t);
        q_a.push_back('{inv: 1'b0, cand: c, total: t});
    endfunction

    function automatic void exp_vote_b(input int c, input int t);
        q_b.push_back('{inv: 1'b0, cand: c, total: t});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        mode_a = 1'b0;
        mode_b = 1'b0;
        btn_a  = '0;
        btn_b  = '0;
        cyc(3);
        check("rst_led", 32'(led_a), 0);
        check("rst_vote_valid", 32'(vv_a), 0);
        check("rst_vote_invalid", 32'(vi_a), 0);
        check("rst_vote_cand", 32'(vc_a), 0);
        check("rst_total", 32'(tot_a), 0);
        reset = 1'b1;
        cyc(3);

        // single long press on candidate 0
        exp_vote_a(0, 1);
        press_a(4'b0001, 20);
        check("t1_pending", 32'(q_a.size()), 0);
        check("t1_total", 32'(tot_a), 1);

        // short press: neither vote nor reject
        press_a(4'b0010, 5);
        check("t2_total", 32'(tot_a), 1);

        // two buttons together: one reject
        q_a.push_back('{inv: 1'b1, cand: 0, total: 0});
        press_a(4'b0110, 20);
        check("t3_pending", 32'(q_a.size()), 0);
        check("t3_total", 32'(tot_a), 1);

        // two votes for candidate 2 then results display
        exp_vote_a(2, 2);
        press_a(4'b0100, 20);
        exp_vote_a(2, 3);
        press_a(4'b0100, 20);
        check("t4_vote_cand", 32'(vc_a), 2);
        check("t4_led_voting", 32'(led_a), 0);
        mode_a = 1'b1;
        cyc(4);
        btn_a = 4'b0100;
        cyc(2);
        btn_a = '0;
        cyc(4);
        check("t4_led_cand2", 32'(led_a), 2);
        btn_a = 4'b0001;
        cyc(1);
        btn_a = '0;
        cyc(5);
        check("t4_led_cand0", 32'(led_a), 1);
        btn_a = 4'b0011;
        cyc(2);
        btn_a = '0;
        cyc(5);
        check("t4_led_keep_sel", 32'(led_a), 1);
        press_a(4'b1000, 20);
        check("t4_led_cand3", 32'(led_a), 0);
        mode_a = 1'b0;
        cyc(6);
        check("t4_led_off", 32'(led_a), 0);
        check("t4_total_unchanged", 32'(tot_a), 3);

        // narrow tallies saturate at 3
        for (int i = 0; i < 5; i++) begin
            exp_vote_b(3, (i < 3) ? i + 1 : 3);
            press_b(4'b1000, 20);
        end
        check("t5_pending", 32'(q_b.size()), 0);
        check("t5_total_sat", 32'(tot_b), 3);
        mode_b = 1'b1;
        cyc(4);
        btn_b = 4'b1000;
        cyc(2);
        btn_b = '0;
        cyc(4);
        check("t5_led_sat", 32'(led_b), 3);
        mode_b = 1'b0;
        cyc(4);

        // reset while armed
        btn_a = 4'b0001;
        cyc(6);
        reset = 1'b0;
        cyc(1);
        btn_a = '0;
        cyc(2);
        reset = 1'b1;
        cyc(10);
        check("t6_rst_total", 32'(tot_a), 0);
        check("t6_rst_led", 32'(led_a), 0);
        check("t6_rst_cand", 32'(vc_a), 0);
        check("t6_rst_valid", 32'(vv_a), 0);
        check("t6_rst_invalid", 32'(vi_a), 0);
        check("t6_rst_total_b", 32'(tot_b), 0);

        // results mode entered while armed
        btn_a = 4'b0010;
        cyc(6);
        mode_a = 1'b1;
        cyc(20);
        btn_a = '0;
        cyc(2);
        mode_a = 1'b0;
        cyc(8);
        check("t6_mode_total", 32'(tot_a), 0);

        // normal voting resumes
        exp_vote_a(3, 1);
        press_a(4'b1000, 20);
        check("t6_recover_total", 32'(tot_a), 1);

        check("final_pending_a", 32'(q_a.size()), 0);
        check("final_pending_b", 32'(q_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
